// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the fetch controller and its instruction queue.
package pc_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] WORD_BYTES       = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/pc_fetch_ctrl_fetch_queue.sv
// Synchronous FIFO of fetched {pc, inst} entries with a flush-style clear.
module fetch_queue
  import pc_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  fetch_entry_t               din,
  output fetch_entry_t               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC owner and single-outstanding instruction fetcher with redirect flush.
// Define PC_FETCH_PERF_EN to add the perf_redirects / perf_stall_cycles counters.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_state,
  input  logic [31:0] final_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_4,
  output logic [31:0] if_inst,
  input  logic        if_ready,
  output logic        flush_out
`ifdef PC_FETCH_PERF_EN
  ,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_stall_cycles
`endif
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  fetch_state_e  state, state_next;
  logic [31:0]   pc, pc_next;
  logic [31:0]   addr;
  logic [31:0]   target;
  logic          squash, squash_next;
  logic          q_push, q_pop, q_full, q_empty;
  logic [CW-1:0] q_count;
  logic [CW-1:0] count_after;
  fetch_entry_t  q_din, q_dout;

  assign target      = final_target & ~32'h3;
  assign q_pop       = if_valid && if_ready;
  assign count_after = q_count + CW'(1) - CW'(q_pop);
  assign q_din       = '{pc: addr, inst: imem_rdata};

  assign imem_req  = (state == REQ);
  assign imem_addr = addr;
  assign if_valid  = !q_empty;
  assign if_pc     = q_dout.pc;
  assign if_pc_4   = q_dout.pc + WORD_BYTES;
  assign if_inst   = q_dout.inst;

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    squash_next = squash;
    q_push      = 1'b0;
    unique case (state)
      IDLE: begin
        if (branch_state) begin
          pc_next    = target;
          state_next = REQ;
        end else if (!q_full) begin
          state_next = REQ;
        end
      end
      // A redirect without ack keeps the old address up; squash marks its response as dead.
      REQ: begin
        if (imem_ack) begin
          state_next  = (squash || branch_state) ? DROP : WAIT;
          squash_next = 1'b0;
          if (branch_state)  pc_next = target;
          else if (!squash)  pc_next = pc + WORD_BYTES;
        end else if (branch_state) begin
          pc_next     = target;
          squash_next = 1'b1;
        end
      end
      WAIT: begin
        if (branch_state) begin
          pc_next    = target;
          state_next = imem_rvalid ? REQ : DROP;
        end else if (imem_rvalid) begin
          q_push     = 1'b1;
          state_next = (count_after < QFULL) ? REQ : IDLE;
        end
      end
      DROP: begin
        if (branch_state) pc_next = target;
        if (imem_rvalid)  state_next = REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      addr      <= RESET_PC;
      squash    <= 1'b0;
      flush_out <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      squash    <= squash_next;
      flush_out <= branch_state;
      // addr is the in-flight request address; it only moves when a new request starts.
      if (state_next == REQ && state != REQ) addr <= pc_next;
    end
  end

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .clear (branch_state),
    .push  (q_push),
    .pop   (q_pop),
    .din   (q_din),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

`ifdef PC_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_redirects    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (branch_state && perf_redirects != '1)
        perf_redirects <= perf_redirects + 1'b1;
      if (if_valid && !if_ready && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a one-cycle-latency instruction memory responder.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_state;
  logic [31:0] final_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_4;
  logic [31:0] if_inst;
  logic        if_ready;
  logic        flush_out;
`ifdef PC_FETCH_PERF_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_stall_cycles;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic        ack_en;
  logic        rv_en;
  logic        pend;
  logic [31:0] pend_addr;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_PC(32'hBFC0_0000), .QDEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .branch_state (branch_state),
    .final_target (final_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_pc_4      (if_pc_4),
    .if_inst      (if_inst),
    .if_ready     (if_ready),
    .flush_out    (flush_out)
`ifdef PC_FETCH_PERF_EN
    ,
    .perf_redirects    (perf_redirects),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  // Memory returns addr ^ A5A50000 one cycle after the accepting handshake.
  task automatic tick();
    logic        fire;
    logic [31:0] a;
    imem_ack    = imem_req && ack_en;
    imem_rvalid = pend && rv_en;
    imem_rdata  = pend_addr ^ 32'hA5A5_0000;
    fire = imem_req && imem_ack;
    a    = imem_addr;
    @(posedge clk);
    if (imem_rvalid) pend = 1'b0;
    if (fire) begin
      pend      = 1'b1;
      pend_addr = a;
    end
    #1;
  endtask

  task automatic do_reset();
    ack_en       = 1'b0;
    rv_en        = 1'b0;
    branch_state = 1'b0;
    rst          = 1'b1;
    tick();
    rst    = 1'b0;
    pend   = 1'b0;
    ack_en = 1'b1;
    rv_en  = 1'b1;
    if_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid got %b want 0", if_valid); end
    checks++; if (flush_out !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", flush_out); end
    checks++; if (imem_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL reset_addr got %h want bfc00000", imem_addr); end
`ifdef PC_FETCH_PERF_EN
    checks++; if (perf_redirects !== 32'd0) begin errors++; $display("FAIL reset_perf_redir got %0d want 0", perf_redirects); end
    checks++; if (perf_stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_perf_stall got %0d want 0", perf_stall_cycles); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    do_reset();
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL free_req0 got %b/%h want 1/bfc00000", imem_req, imem_addr); end
    tick();
    checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL free_wait0 got req %b valid %b want 0/0", imem_req, if_valid); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'hBFC0_0000) begin errors++; $display("FAIL free_head0 got %b/%h want 1/bfc00000", if_valid, if_pc); end
    checks++; if (if_pc_4 !== 32'hBFC0_0004) begin errors++; $display("FAIL free_pc4 got %h want bfc00004", if_pc_4); end
    checks++; if (if_inst !== 32'h1A65_0000) begin errors++; $display("FAIL free_inst0 got %h want 1a650000", if_inst); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0004) begin errors++; $display("FAIL free_req1 got %b/%h want 1/bfc00004", imem_req, imem_addr); end
    tick();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL free_popped got %b want 0", if_valid); end
    tick();
    checks++; if (if_pc !== 32'hBFC0_0004 || if_inst !== 32'h1A65_0004) begin errors++; $display("FAIL free_head1 got %h/%h want bfc00004/1a650004", if_pc, if_inst); end
    checks++; if (imem_addr !== 32'hBFC0_0008) begin errors++; $display("FAIL free_req2 got %h want bfc00008", imem_addr); end
    tick();
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'hBFC0_0008) begin errors++; $display("FAIL free_head2 got %b/%h want 1/bfc00008", if_valid, if_pc); end
  endtask

  task automatic test_stall();
    do_reset();
    if_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'hBFC0_0000) begin errors++; $display("FAIL stall_head got %b/%h want 1/bfc00000", if_valid, if_pc); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_full_req got %b want 0", imem_req); end
    for (int i = 0; i < 4; i++) tick();
    checks++; if (imem_req !== 1'b0 || if_pc !== 32'hBFC0_0000) begin errors++; $display("FAIL stall_hold got %b/%h want 0/bfc00000", imem_req, if_pc); end
`ifdef PC_FETCH_PERF_EN
    checks++; if (perf_stall_cycles !== 32'd6) begin errors++; $display("FAIL stall_perf got %0d want 6", perf_stall_cycles); end
`endif
    if_ready = 1'b1;
    tick();
    checks++; if (if_pc !== 32'hBFC0_0004 || imem_req !== 1'b0) begin errors++; $display("FAIL stall_pop0 got %h/%b want bfc00004/0", if_pc, imem_req); end
    tick();
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0008) begin errors++; $display("FAIL stall_resume got %b/%b/%h want 0/1/bfc00008", if_valid, imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    tick();
    tick();
    branch_state = 1'b1;
    final_target = 32'h8000_1000;
    rv_en        = 1'b0;
    tick();
    branch_state = 1'b0;
    checks++; if (flush_out !== 1'b1 || if_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rw_flush got %b/%b/%b want 1/0/0", flush_out, if_valid, imem_req); end
`ifdef PC_FETCH_PERF_EN
    checks++; if (perf_redirects !== 32'd1) begin errors++; $display("FAIL rw_perf got %0d want 1", perf_redirects); end
`endif
    rv_en = 1'b1;
    tick();
    checks++; if (flush_out !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL rw_drop got %b/%b want 0/0", flush_out, if_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_1000) begin errors++; $display("FAIL rw_target got %b/%h want 1/80001000", imem_req, imem_addr); end
    tick();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rw_nostale got %b want 0", if_valid); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_1000) begin errors++; $display("FAIL rw_head got %b/%h want 1/80001000", if_valid, if_pc); end
  endtask

  task automatic test_redirect_rvalid();
    do_reset();
    tick();
    tick();
    branch_state = 1'b1;
    final_target = 32'h8000_1000;
    tick();
    branch_state = 1'b0;
    checks++; if (if_valid !== 1'b0 || flush_out !== 1'b1) begin errors++; $display("FAIL rr_discard got %b/%b want 0/1", if_valid, flush_out); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_1000) begin errors++; $display("FAIL rr_req got %b/%h want 1/80001000", imem_req, imem_addr); end
    tick();
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_1000) begin errors++; $display("FAIL rr_head got %b/%h want 1/80001000", if_valid, if_pc); end
  endtask

  task automatic test_redirect_req();
    do_reset();
    ack_en = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL rq_req got %b/%h want 1/bfc00000", imem_req, imem_addr); end
    branch_state = 1'b1;
    final_target = 32'h8000_1000;
    tick();
    branch_state = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0000 || flush_out !== 1'b1) begin errors++; $display("FAIL rq_hold0 got %b/%h/%b want 1/bfc00000/1", imem_req, imem_addr, flush_out); end
    tick();
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL rq_hold2 got %b/%h want 1/bfc00000", imem_req, imem_addr); end
    ack_en = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rq_drop got %b want 0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_1000 || if_valid !== 1'b0) begin errors++; $display("FAIL rq_target got %b/%h/%b want 1/80001000/0", imem_req, imem_addr, if_valid); end
    tick();
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_1000) begin errors++; $display("FAIL rq_head got %b/%h want 1/80001000", if_valid, if_pc); end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    branch_state = 1'b1;
    final_target = 32'hFFFF_FFFF;
    tick();
    branch_state = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_align got %b/%h want 1/fffffffc", imem_req, imem_addr); end
    tick();
    tick();
    checks++; if (if_pc !== 32'hFFFF_FFFC || if_pc_4 !== 32'h0000_0000) begin errors++; $display("FAIL wr_pc4 got %h/%h want fffffffc/00000000", if_pc, if_pc_4); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0000) begin errors++; $display("FAIL wr_wrap got %b/%h want 1/00000000", imem_req, imem_addr); end
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wr_wait got %b want 0", imem_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL wr_rst got %b/%b/%h want 0/0/bfc00000", imem_req, if_valid, imem_addr); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL wr_restart got %b/%h want 1/bfc00000", imem_req, imem_addr); end
  endtask

  initial begin
    rst          = 1'b1;
    branch_state = 1'b0;
    final_target = '0;
    imem_ack     = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = '0;
    if_ready     = 1'b1;
    ack_en       = 1'b0;
    rv_en        = 1'b0;
    pend         = 1'b0;
    pend_addr    = '0;
    #1;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_redirect_req();
    test_wrap_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
